// File: rtl/exec_unit_pipe_if.sv
// Operand/result handshake bundle of the execute stage.
// master drives operands and out_ready; slave is the execute unit.
interface exec_unit_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      ir;
    logic [WIDTH-1:0] npc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic             cond;
    logic [WIDTH-1:0] res;
    logic             busy;

    modport master (
        output in_valid, ir, npc, a, b, imm, out_ready,
        input  in_ready, out_valid, cond, res, busy
    );

    modport slave (
        input  in_valid, ir, npc, a, b, imm, out_ready,
        output in_ready, out_valid, cond, res, busy
    );
endinterface

// File: rtl/exec_unit_pipe.sv
// Registered MIPS execute stage with valid/ready on both sides.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (opcode 000110).
module exec_unit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    exec_unit_pipe_if.slave bus
);
    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR  = 6'b000011;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_SLT = 6'b000101;
    localparam logic [5:0] OP_LD  = 6'b010000;
    localparam logic [5:0] OP_ST  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t           state, state_d;
    logic [5:0]       opcode;
    logic             in_fire, out_fire, is_mul, mul_done;
    logic [WIDTH-1:0] res_c, mul_res;
    logic             cond_c;
    logic             out_valid_q, cond_q;
    logic [WIDTH-1:0] res_q;
    logic             unused_ir;

    assign opcode    = bus.ir[31:26];
    assign unused_ir = ^bus.ir[25:0];

    assign bus.in_ready  = !rst && (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.cond      = cond_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    // Single-cycle result and branch condition
    always_comb begin
        res_c  = '0;
        cond_c = 1'b0;
        case (opcode)
            OP_ADD:        res_c = bus.a + bus.b;
            OP_SUB:        res_c = bus.a - bus.b;
            OP_AND:        res_c = bus.a & bus.b;
            OP_OR:         res_c = bus.a | bus.b;
            OP_XOR:        res_c = bus.a ^ bus.b;
            OP_SLT:        res_c = WIDTH'(bus.a < bus.b);
            OP_LD, OP_ST:  res_c = bus.a + bus.imm;
            OP_BEQ: begin
                res_c  = bus.npc + bus.imm;
                cond_c = (bus.a == '0);
            end
            OP_JMP: begin
                res_c  = bus.imm;
                cond_c = 1'b1;
            end
            default:       res_c = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam logic [5:0] OP_MUL = 6'b000110;

    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;

    assign is_mul   = (opcode == OP_MUL);
    assign mul_done = (state == MUL) && (cnt == CNT_W'(WIDTH - 1));
    assign mul_res  = mplier[0] ? acc + mcand : acc;
    assign bus.busy = (state == MUL);

    // One shift-add step per cycle; operands captured at acceptance
    always_ff @(posedge clk) begin
        if (in_fire && is_mul) begin
            acc    <= '0;
            mcand  <= bus.a;
            mplier <= bus.b;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= mul_res;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_fire && is_mul) state_d = MUL;
            MUL:     if (mul_done)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output register: held until the downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            cond_q      <= 1'b0;
        end else if (in_fire && !is_mul) begin
            out_valid_q <= 1'b1;
            res_q       <= res_c;
            cond_q      <= cond_c;
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            res_q       <= mul_res;
            cond_q      <= 1'b0;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
